// File: rtl/pc_stack_engine_pkg.sv
// ---------------------------------------------------------------------------
// pc_stack_engine_pkg
// Shared CPU types for the PC stack engine: operation modes, sequencer
// states, fixed bus widths and the X-register increment helper.
// ---------------------------------------------------------------------------
package pc_stack_engine_pkg;

  // Operation requested on start (encoding is part of the CPU opcode map)
  typedef enum logic [1:0] {
    MODE_PUSH     = 2'd0,
    MODE_POP      = 2'd1,
    MODE_POP_SKIP = 2'd2,
    MODE_POP_IMM  = 2'd3
  } mode_t;

  // Nibble sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_WR = 3'd1,
    ST_POP_RD  = 3'd2,
    ST_IMM_WR  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int RAM_ADDR_W = 12;
  localparam int X_W        = 12;
  localparam int NIB_W      = 4;

  // X advances inside its low page only; the page bits x[11:8] never change.
  function automatic logic [X_W-1:0] x_inc(input logic [X_W-1:0] x);
    return {x[11:8], x[7:0] + 8'd1};
  endfunction

endpackage

// File: rtl/pc_stack_engine.sv
// ---------------------------------------------------------------------------
// pc_stack_engine
// Moves a multi-nibble program counter between the CPU and a 4-bit wide
// external RAM, one nibble per enabled CPU cycle.
//   PUSH     : writes pc_in MSB-nibble first below sp_in, sp_out = sp_in-NIBBLES
//   POP      : reads NIBBLES nibbles upward from sp_in, sp_out = sp_in+NIBBLES
//   POP_SKIP : POP, then the low STEP_WIDTH bits of the PC are incremented
//   POP_IMM  : POP, then IMM_NIBBLES immediate nibbles are stored at X, X++
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   clk_en          : CPU cycle enable; nothing moves while low
//   start, mode     : operation request (sampled only while idle)
//   pc_in, sp_in,
//   x_in, imm       : operands, latched when the request is accepted
//   ram_addr/we/wdata/rdata : external nibble RAM (read data one enabled
//                     cycle after its address)
//   pc_out, sp_out, x_out : results
//   busy, done      : operation in progress / one-enabled-cycle completion
// ---------------------------------------------------------------------------
module pc_stack_engine
  import pc_stack_engine_pkg::*;
#(
  parameter int NIBBLES     = 3,
  parameter int SP_WIDTH    = 8,
  parameter int STEP_WIDTH  = 8,
  parameter int IMM_NIBBLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [4*NIBBLES-1:0]        pc_in,
  input  logic [SP_WIDTH-1:0]         sp_in,
  input  logic [X_W-1:0]              x_in,
  input  logic [4*IMM_NIBBLES-1:0]    imm,
  output logic [RAM_ADDR_W-1:0]       ram_addr,
  output logic                        ram_we,
  output logic [NIB_W-1:0]            ram_wdata,
  input  logic [NIB_W-1:0]            ram_rdata,
  output logic [4*NIBBLES-1:0]        pc_out,
  output logic [SP_WIDTH-1:0]         sp_out,
  output logic [X_W-1:0]              x_out,
  output logic                        busy,
  output logic                        done
);

  localparam int CNT_W = $clog2(NIBBLES + IMM_NIBBLES + 2);
  localparam logic [CNT_W-1:0] PUSH_LAST = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] POP_LAST  = CNT_W'(NIBBLES);
  localparam logic [CNT_W-1:0] IMM_LAST  = CNT_W'(IMM_NIBBLES - 1);

  state_t                     state_r;
  mode_t                      mode_r;
  logic [CNT_W-1:0]           step_r;
  logic [SP_WIDTH-1:0]        sp_base_r;
  logic [4*IMM_NIBBLES-1:0]   imm_r;
  logic [4*NIBBLES-1:0]       pc_r;
  logic [SP_WIDTH-1:0]        sp_r;
  logic [X_W-1:0]             x_r;
  logic [RAM_ADDR_W-1:0]      addr_r;
  logic [NIB_W-1:0]           wdata_r;
  logic                       we_r;
  logic                       busy_r;
  logic                       done_r;

  int                         rd_idx_s;
  int                         push_idx_s;
  int                         imm_idx_s;
  logic [4*NIBBLES-1:0]       filled_pc_s;
  logic [4*NIBBLES-1:0]       pop_pc_s;
  logic [NIB_W-1:0]           push_wdata_s;
  logic [NIB_W-1:0]           imm_wdata_s;

  // Stack pointers are narrower than the RAM bus; upper address bits are zero.
  function automatic logic [RAM_ADDR_W-1:0] stack_addr(input logic [SP_WIDTH-1:0] a);
    return RAM_ADDR_W'(a);
  endfunction

  // Read data lags its address by one step, so step k stores nibble k-1.
  always_comb begin
    rd_idx_s = int'(step_r) - 32'sd1;
    if (rd_idx_s >= 0 && rd_idx_s < NIBBLES) begin
      filled_pc_s = pc_r;
      filled_pc_s[4*rd_idx_s +: 4] = ram_rdata;
    end else begin
      filled_pc_s = pc_r;
    end
  end

  // POP_SKIP bumps only the low step field on the final read step.
  always_comb begin
    if (step_r == POP_LAST && mode_r == MODE_POP_SKIP) begin
      pop_pc_s = filled_pc_s;
      pop_pc_s[STEP_WIDTH-1:0] = filled_pc_s[STEP_WIDTH-1:0] + STEP_WIDTH'(1);
    end else begin
      pop_pc_s = filled_pc_s;
    end
  end

  // Write data for the step that follows the current one.
  always_comb begin
    push_idx_s = NIBBLES - 2 - int'(step_r);
    imm_idx_s  = int'(step_r) + 32'sd1;
    if (push_idx_s >= 0 && push_idx_s < NIBBLES) begin
      push_wdata_s = pc_r[4*push_idx_s +: 4];
    end else begin
      push_wdata_s = 4'd0;
    end
    if (imm_idx_s >= 0 && imm_idx_s < IMM_NIBBLES) begin
      imm_wdata_s = imm_r[4*imm_idx_s +: 4];
    end else begin
      imm_wdata_s = 4'd0;
    end
  end

  // Sequencer FSM; RAM controls are registered one step ahead of their use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      mode_r    <= MODE_PUSH;
      step_r    <= '0;
      sp_base_r <= '0;
      imm_r     <= '0;
      pc_r      <= '0;
      sp_r      <= '0;
      x_r       <= '0;
      addr_r    <= '0;
      wdata_r   <= 4'd0;
      we_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (clk_en) begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          we_r   <= 1'b0;
          if (start) begin
            mode_r    <= mode_t'(mode);
            sp_base_r <= sp_in;
            imm_r     <= imm;
            pc_r      <= pc_in;
            sp_r      <= sp_in;
            x_r       <= x_in;
            step_r    <= '0;
            busy_r    <= 1'b1;
            if (mode_t'(mode) == MODE_PUSH) begin
              state_r <= ST_PUSH_WR;
              we_r    <= 1'b1;
              addr_r  <= stack_addr(sp_in - SP_WIDTH'(1));
              wdata_r <= pc_in[4*(NIBBLES-1) +: 4];
            end else begin
              state_r <= ST_POP_RD;
              we_r    <= 1'b0;
              addr_r  <= stack_addr(sp_in);
            end
          end
        end

        ST_PUSH_WR: begin
          // sp_r tracks the address just written, ending at sp_in-NIBBLES
          sp_r <= sp_r - SP_WIDTH'(1);
          if (step_r == PUSH_LAST) begin
            state_r <= ST_DONE;
            we_r    <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            step_r  <= step_r + CNT_W'(1);
            addr_r  <= stack_addr(sp_r - SP_WIDTH'(2));
            wdata_r <= push_wdata_s;
          end
        end

        ST_POP_RD: begin
          pc_r <= pop_pc_s;
          if (step_r == POP_LAST) begin
            sp_r <= sp_base_r + SP_WIDTH'(NIBBLES);
            if (mode_r == MODE_POP_IMM) begin
              state_r <= ST_IMM_WR;
              step_r  <= '0;
              we_r    <= 1'b1;
              addr_r  <= x_r;
              wdata_r <= imm_r[3:0];
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            step_r <= step_r + CNT_W'(1);
            // the trailing step only collects data, so the address is held
            if (step_r < PUSH_LAST) begin
              addr_r <= stack_addr(sp_base_r + SP_WIDTH'(step_r) + SP_WIDTH'(1));
            end else begin
              addr_r <= addr_r;
            end
          end
        end

        ST_IMM_WR: begin
          x_r <= x_inc(x_r);
          if (step_r == IMM_LAST) begin
            state_r <= ST_DONE;
            we_r    <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            step_r  <= step_r + CNT_W'(1);
            addr_r  <= x_inc(x_r);
            wdata_r <= imm_wdata_s;
          end
        end

        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          we_r    <= 1'b0;
        end

        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr  = addr_r;
  assign ram_wdata = wdata_r;
  // a frozen cycle must never commit a write, so the strobe follows clk_en
  assign ram_we    = we_r & clk_en;
  assign pc_out    = pc_r;
  assign sp_out    = sp_r;
  assign x_out     = x_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_pc_stack_engine.sv
// ---------------------------------------------------------------------------
// tb_pc_stack_engine
// Self-checking bench: nibble RAM model, directed scenarios and random
// operations compared with an arithmetic reference of the stack rules.
// ---------------------------------------------------------------------------
module tb_pc_stack_engine;

  localparam int NIB  = 3;
  localparam int IMMN = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [1:0]  mode;
  logic [11:0] pc_in;
  logic [7:0]  sp_in;
  logic [11:0] x_in;
  logic [7:0]  imm;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata;
  logic [3:0]  rdata_q;
  logic [11:0] pc_out;
  logic [7:0]  sp_out;
  logic [11:0] x_out;
  logic        busy;
  logic        done;

  logic [3:0]  mem     [4096];
  logic [3:0]  ref_mem [4096];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [3:0]  bd_data;
  int          wr_cnt = 0;
  int          gap_we = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  pc_stack_engine dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .mode(mode),
    .pc_in(pc_in), .sp_in(sp_in), .x_in(x_in), .imm(imm),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(rdata_q),
    .pc_out(pc_out), .sp_out(sp_out), .x_out(x_out), .busy(busy), .done(done)
  );

  // synchronous nibble RAM with a backdoor preload port
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (clk_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wr_cnt <= wr_cnt + 1;
      end
      rdata_q <= mem[ram_addr];
    end
  end

  // a write strobe while the CPU cycle is disabled is an error
  always @(negedge clk) begin
    if (!clk_en && ram_we) gap_we <= gap_we + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic bd_write(input logic [11:0] a, input logic [3:0] d);
    @(negedge clk);
    clk_en = 1'b0; bd_we = 1'b1; bd_addr = a; bd_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] m, input logic [11:0] pc, input logic [7:0] sp,
                        input logic [11:0] x, input logic [7:0] im, input bit gaps, input string tag);
    logic [11:0] e_pc;
    logic [11:0] xx;
    logic [7:0]  e_sp;
    logic [7:0]  a;
    int          e_lat, e_wr, lat, w0;
    bit          seen;
    // reference: plain stack arithmetic on the shadow memory
    e_pc = 12'h000; xx = x; e_wr = 0;
    if (m == 2'd0) begin
      for (int k = 0; k < NIB; k++) begin
        a = sp - 8'(k + 1);
        ref_mem[{4'h0, a}] = pc[4*(NIB-1-k) +: 4];
      end
      e_sp = sp - 8'(NIB); e_lat = NIB + 1; e_wr = NIB;
    end else begin
      for (int k = 0; k < NIB; k++) begin
        a = sp + 8'(k);
        e_pc[4*k +: 4] = ref_mem[{4'h0, a}];
      end
      if (m == 2'd2) e_pc[7:0] = e_pc[7:0] + 8'd1;
      e_sp = sp + 8'(NIB); e_lat = NIB + 2;
      if (m == 2'd3) begin
        for (int j = 0; j < IMMN; j++) begin
          ref_mem[xx] = im[4*j +: 4];
          xx[7:0] = xx[7:0] + 8'd1;
        end
        e_lat = e_lat + IMMN; e_wr = IMMN;
      end
    end

    w0 = wr_cnt;
    @(negedge clk);
    clk_en = 1'b1; start = 1'b1; mode = m; pc_in = pc; sp_in = sp; x_in = x; imm = im;
    @(posedge clk); #1;
    check_val({tag, ":busy"}, {31'd0, busy}, 32'd1);
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      // junk requests while busy must be ignored
      start = 1'($urandom); mode = 2'($urandom); pc_in = 12'($urandom);
      sp_in = 8'($urandom); x_in = 12'($urandom); imm = 8'($urandom);
      clk_en = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk);
      if (clk_en) lat++;
      #1;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      check_val({tag, ":timeout"}, 32'd0, 32'd1);
    end else begin
      check_val({tag, ":lat"}, lat, e_lat);
      check_val({tag, ":busy_done"}, {31'd0, busy}, 32'd1);
      if (m != 2'd0) check_val({tag, ":pc"}, {20'd0, pc_out}, {20'd0, e_pc});
      check_val({tag, ":sp"}, {24'd0, sp_out}, {24'd0, e_sp});
      check_val({tag, ":x"}, {20'd0, x_out}, {20'd0, xx});
    end
    clk_en = 1'b1;
    @(posedge clk); #1;
    check_val({tag, ":done_pulse"}, {30'd0, done, busy}, 32'd0);
    check_val({tag, ":writes"}, wr_cnt - w0, e_wr);
    check_val({tag, ":mem"}, mem_diffs(), 32'd0);
  endtask

  initial begin
    int w0;
    reset = 1'b1; clk_en = 1'b0; start = 1'b0; mode = 2'd0; pc_in = 12'h000;
    sp_in = 8'h00; x_in = 12'h000; imm = 8'h00;
    bd_we = 1'b0; bd_addr = 12'h000; bd_data = 4'h0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_we", {31'd0, ram_we}, 32'd0);
    check_val("rst_addr", {20'd0, ram_addr}, 32'd0);
    check_val("rst_wdata", {28'd0, ram_wdata}, 32'd0);
    check_val("rst_pc", {20'd0, pc_out}, 32'd0);
    check_val("rst_sp", {24'd0, sp_out}, 32'd0);
    check_val("rst_x", {20'd0, x_out}, 32'd0);
    for (int i = 0; i < 4096; i++) bd_write(12'(i), 4'($urandom));
    @(negedge clk); reset = 1'b0;

    // directed scenarios
    bd_write(12'h044, 4'hD); bd_write(12'h045, 4'h4); bd_write(12'h046, 4'h7);
    run_op(2'd1, 12'h000, 8'h44, 12'h123, 8'h00, 1'b0, "pop");
    check_val("pop_pc_const", {20'd0, pc_out}, 32'h74D);
    check_val("pop_sp_const", {24'd0, sp_out}, 32'h47);
    run_op(2'd2, 12'h000, 8'h44, 12'h123, 8'h00, 1'b0, "skip");
    check_val("skip_pc_const", {20'd0, pc_out}, 32'h74E);
    bd_write(12'h044, 4'hF); bd_write(12'h045, 4'hF);
    run_op(2'd2, 12'h000, 8'h44, 12'h123, 8'h00, 1'b0, "skip_wrap");
    check_val("skip_wrap_const", {20'd0, pc_out}, 32'h700);
    bd_write(12'h044, 4'hD); bd_write(12'h045, 4'h4);
    run_op(2'd3, 12'h000, 8'h44, 12'h1F1, 8'hFC, 1'b0, "imm");
    check_val("imm_x_const", {20'd0, x_out}, 32'h1F3);
    check_val("imm_m1f1", {28'd0, mem[12'h1F1]}, 32'hC);
    check_val("imm_m1f2", {28'd0, mem[12'h1F2]}, 32'hF);
    run_op(2'd0, 12'h74D, 8'h02, 12'h000, 8'h00, 1'b0, "push");
    check_val("push_m01", {28'd0, mem[12'h001]}, 32'h7);
    check_val("push_m00", {28'd0, mem[12'h000]}, 32'h4);
    check_val("push_mff", {28'd0, mem[12'h0FF]}, 32'hD);
    check_val("push_sp_const", {24'd0, sp_out}, 32'hFF);
    run_op(2'd3, 12'h000, 8'h44, 12'h1FF, 8'h5A, 1'b1, "imm_gap");
    run_op(2'd0, 12'hABC, 8'h80, 12'h3C0, 8'h00, 1'b1, "push_gap");

    // reset during the second push step
    @(negedge clk);
    clk_en = 1'b1; start = 1'b1; mode = 2'd0; pc_in = 12'h5A3; sp_in = 8'h90; x_in = 12'h000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    ref_mem[12'h08F] = 4'h5;
    w0 = wr_cnt;
    reset = 1'b1; #1;
    check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_val("rst_mid_we", {31'd0, ram_we}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_mid_writes", wr_cnt - w0, 32'd0);
    check_val("rst_mid_outs", {pc_out, sp_out, x_out}, 32'd0);
    check_val("rst_mid_mem", mem_diffs(), 32'd0);
    @(negedge clk); reset = 1'b0;
    run_op(2'd0, 12'h321, 8'h10, 12'h000, 8'h00, 1'b0, "push_after_rst");

    // random operations
    for (int n = 0; n < 40; n++) begin
      run_op(2'($urandom), 12'($urandom), 8'($urandom), 12'($urandom), 8'($urandom),
             1'($urandom), $sformatf("rnd%0d", n));
    end
    check_val("we_in_gap", gap_we, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
